uart_rx_engine: RTL and testbench
=================================

Name: uart_rx_engine

Overview:
- Receive half of the full UART: deserialises the asynchronous line frame produced by the transmit shift register.
- Frame on the line: idle 1, start 0, data LSB-first (7 or 8 bits), optional parity bit, one stop bit 1.
- Presents a parallel byte plus status flags to the host/status logic, held until the host reads.
- Mid-bit sampling against a programmable bit-period count shared with the transmit side.

Parameters:
- BAUD_W, 20, width of the bit-period count input baud_k.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low (0 = reset, sampled on the rising edge of clk).
- rx  in  1  asynchronous serial line, idle high.
- baud_k  in  BAUD_W  clocks per bit; legal values are 4 or more, held stable while a frame is in progress.
- eight  in  1  1 = 8 data bits, 0 = 7 data bits.
- pen  in  1  parity enable.
- ohel  in  1  parity sense: 1 = odd, 0 = even.
- read  in  1  one-cycle host strobe; consumes rx_data.
- rx_data  out  8  received data; bit7 forced to 0 in 7-bit mode.
- rx_rdy  out  1  new data available.
- perr  out  1  parity error on the last frame.
- ferr  out  1  framing error on the last frame (stop bit sampled 0).
- ovf  out  1  overrun: a frame completed while rx_rdy was still 1.

Behaviour:
- Reset (rst=0 at a clock edge):
  - all outputs go to 0 and the FSM goes to IDLE.
  - synchroniser flops preset to 1.
  - a reset asserted mid-frame abandons the frame with no flags set.
- rx passes through a 2-flop synchroniser. All references below to rx mean the synchronised value rxs.
- Counters: bit-period counter of BAUD_W bits; bit counter of 4 bits. half = baud_k >> 1.
- IDLE:
  - stays while rxs=1.
  - on rxs=0, clears the bit counter, loads the period counter and goes to START.
- START:
  - after half clocks, samples rxs.
  - rxs=1 is a false start: return to IDLE, no flag changes.
  - rxs=0 goes to DATA.
- DATA:
  - samples every baud_k clocks, shifting right into the data register (LSB first).
  - after 7 samples (eight=0) or 8 samples (eight=1), goes to PAR if pen=1, else to STOP.
- PAR:
  - samples the parity bit after baud_k clocks.
  - expected bit = XOR of the received data bits, XOR ohel.
  - a mismatch sets the internal parity-fail bit.
- STOP: samples the stop bit after baud_k clocks, then goes to DONE.
- DONE (one cycle):
  - rx_data <= data, with bit7=0 in 7-bit mode.
  - perr <= parity-fail, or 0 when pen=0.
  - ferr <= (stop sample == 0).
  - ovf <= 1 if rx_rdy=1 and read=0 this cycle.
  - rx_rdy <= 1.
  - return to IDLE.
- DONE does not wait for the line to return high. If ferr (rx still 0), IDLE immediately sees rxs=0 and starts a new frame; this behaviour is required.
- Latency: rx_rdy rises exactly 1 clock after the stop-bit sample edge.
- read:
  - read=1 with no completion in the same cycle clears rx_rdy and ovf.
  - perr, ferr and rx_data hold until the next frame completes.
- read and DONE in the same cycle: the new frame wins. rx_rdy=1, ovf=0, and new data/flags are loaded.
- read while rx_rdy=0 has no effect.
- baud_k changing mid-frame is undefined; the bench does not test it.

Test Plan:
1. 8N1 frame (baud_k=16, eight=1, pen=0), data 0xA5 -> rx_rdy=1 exactly 1 clk after the stop sample; rx_data=0xA5, perr=0, ferr=0, ovf=0.
2. 7E1 frame (eight=0, pen=1, ohel=0), data 7'h25, parity bit 1 -> rx_data=0x25, perr=0. Repeat with the parity bit driven 0 -> perr=1, rx_data=0x25.
3. Stop bit driven 0 on an 8N1 frame with data 0x3C -> ferr=1, rx_rdy=1, rx_data=0x3C. With rx then held low, a new frame starts immediately (FSM leaves IDLE on the next cycle).
4. Glitch: rx low for 4 clks (baud_k=16), then high -> no rx_rdy, all flags unchanged, FSM back in IDLE.
5. Overrun:
   - Two 8N1 frames 0x11 then 0x22 with no read -> ovf=1, rx_data=0x22.
   - Pulse read -> rx_rdy=0, ovf=0.
   - Third frame with read coincident with DONE -> rx_rdy=1, ovf=0.
6. rst=0 for one clk in the middle of the DATA bits of frame 0x5A -> on the next edge all outputs are 0 and the FSM is in IDLE. A following clean frame 0xC3 is received correctly with no error flags.

Source files
------------

// File: rtl/uart_rx_engine.sv
// UART receive engine: 2-flop synchronised line, mid-bit sampling against baud_k,
// 7/8 data bits LSB first, optional parity, one stop bit, host-held result register.
module uart_rx_engine #(
    parameter int BAUD_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic [BAUD_W-1:0] baud_k,
    input  logic              eight,
    input  logic              pen,
    input  logic              ohel,
    input  logic              read,
    output logic [7:0]        rx_data,
    output logic              rx_rdy,
    output logic              perr,
    output logic              ferr,
    output logic              ovf,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [BAUD_W-1:0] ONE = BAUD_W'(1);

    state_t            state, state_n;
    logic              rx_s1, rxs;
    logic [BAUD_W-1:0] cnt, cnt_n, half;
    logic [3:0]        bitcnt, bitcnt_n, last_bit;
    logic [7:0]        shreg, shreg_n, frame_data;
    logic              pfail, pfail_n;
    logic              stop_bit, stop_bit_n;
    logic              tick, data_par;

    assign half       = baud_k >> 1;
    assign tick       = (cnt == '0);
    assign last_bit   = eight ? 4'd7 : 4'd6;
    // In 7-bit mode the last sample lands in bit 7, so the byte sits one place high.
    assign frame_data = eight ? shreg : {1'b0, shreg[7:1]};
    assign data_par   = ^frame_data;
    assign state_dbg  = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rxs   <= rx_s1;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bitcnt_n   = bitcnt;
        shreg_n    = shreg;
        pfail_n    = pfail;
        stop_bit_n = stop_bit;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_n  = START;
                    cnt_n    = half - ONE;
                    bitcnt_n = 4'd0;
                    pfail_n  = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    if (rxs) begin
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                        cnt_n   = baud_k - ONE;
                    end
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_n  = {rxs, shreg[7:1]};
                    cnt_n    = baud_k - ONE;
                    bitcnt_n = bitcnt + 4'd1;
                    if (bitcnt == last_bit) begin
                        state_n = pen ? PAR : STOP;
                    end
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            PAR: begin
                if (tick) begin
                    pfail_n = (rxs != (data_par ^ ohel));
                    cnt_n   = baud_k - ONE;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            STOP: begin
                if (tick) begin
                    stop_bit_n = rxs;
                    state_n    = DONE;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bitcnt   <= 4'd0;
            shreg    <= 8'd0;
            pfail    <= 1'b0;
            stop_bit <= 1'b0;
            rx_data  <= 8'd0;
            rx_rdy   <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bitcnt   <= bitcnt_n;
            shreg    <= shreg_n;
            pfail    <= pfail_n;
            stop_bit <= stop_bit_n;
            // A completing frame takes priority over a coincident host read.
            if (state == DONE) begin
                rx_data <= frame_data;
                perr    <= pen & pfail;
                ferr    <= ~stop_bit;
                ovf     <= rx_rdy & ~read;
                rx_rdy  <= 1'b1;
            end else if (read) begin
                rx_rdy <= 1'b0;
                ovf    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Bench for uart_rx_engine: table of frames plus hand sequences for ferr restart,
// glitch, overrun, read/DONE collision and mid-frame reset.
module tb_uart_rx_engine;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [19:0] baud_k;
    logic        eight, pen, ohel, read;
    logic [7:0]  rx_data;
    logic        rx_rdy, perr, ferr, ovf;
    logic [2:0]  state_dbg;

    uart_rx_engine #(.BAUD_W(20)) dut (
        .clk(clk), .rst(rst), .rx(rx), .baud_k(baud_k), .eight(eight),
        .pen(pen), .ohel(ohel), .read(read), .rx_data(rx_data),
        .rx_rdy(rx_rdy), .perr(perr), .ferr(ferr), .ovf(ovf),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // expected {rx_rdy, ovf, ferr, perr, rx_data} at each frame completion
    logic [11:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          start_cyc = 0;
    int          rise_cyc = 0;
    logic        last_rdy = 1'b0;
    logic [2:0]  prev_state = 3'd0;
    logic [2:0]  st_a, st_b;

    typedef struct {
        logic [7:0] d;
        logic       e8, pe, od, pbit, stopb;
        int         bk;
        logic [7:0] exp_d;
        logic       exp_perr, exp_ferr;
    } vec_t;
    vec_t vec[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic monitor();
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (rx_rdy && !last_rdy) rise_cyc = cyc;
            last_rdy = rx_rdy;
            if (prev_state == S_DONE) begin
                if (exp_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL unexpected_frame: got %0h", {rx_rdy, ovf, ferr, perr, rx_data});
                end else begin
                    e = exp_q.pop_front();
                    check("frame_result", {20'd0, rx_rdy, ovf, ferr, perr, rx_data}, {20'd0, e});
                end
            end
            prev_state = state_dbg;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic e8, input logic pe,
                              input logic pbit, input logic stopb, input int bk,
                              input logic idle_lvl);
        int nb;
        nb = e8 ? 8 : 7;
        @(negedge clk);
        start_cyc = cyc;
        rx = 1'b0;
        repeat (bk) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            rx = d[i];
            repeat (bk) @(negedge clk);
        end
        if (pe) begin
            rx = pbit;
            repeat (bk) @(negedge clk);
        end
        rx = stopb;
        repeat (bk) @(negedge clk);
        rx = idle_lvl;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL frame_timeout: pending %0d expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pulse_read();
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic read_on_done();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (state_dbg == S_DONE) found = 1'b1;
        end
        check("read_on_done_seen", {31'd0, found}, 32'd1);
        if (found) pulse_read();
    endtask

    task automatic set_cfg(input int bk, input logic e8, input logic pe, input logic od);
        baud_k = 20'(bk);
        eight  = e8;
        pen    = pe;
        ohel   = od;
    endtask

    initial begin
        vec[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16, 8'hA5, 1'b0, 1'b0};
        vec[1] = '{8'h25, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16, 8'h25, 1'b0, 1'b0};
        vec[2] = '{8'h25, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16, 8'h25, 1'b1, 1'b0};
        vec[3] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16, 8'h3C, 1'b0, 1'b1};
        vec[4] = '{8'h81, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16, 8'h81, 1'b0, 1'b0};
        vec[5] = '{8'h81, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16, 8'h81, 1'b1, 1'b0};
        vec[6] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4,  8'h7F, 1'b0, 1'b0};
        vec[7] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5,  8'h00, 1'b0, 1'b0};
        vec[8] = '{8'h6B, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7,  8'h6B, 1'b0, 1'b1};

        rst = 1'b0;
        rx = 1'b1;
        read = 1'b0;
        set_cfg(16, 1'b1, 1'b0, 1'b0);
        fork monitor(); join_none
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_outputs", {20'd0, rx_rdy, ovf, ferr, perr, rx_data}, 32'd0);
        check("reset_state", {29'd0, state_dbg}, {29'd0, S_IDLE});

        // table-driven frames, each read back and cleared
        for (int v = 0; v < 9; v++) begin
            int nb, lat;
            nb  = vec[v].e8 ? 8 : 7;
            lat = 3 + vec[v].bk / 2 + (nb + int'(vec[v].pe) + 1) * vec[v].bk + 1;
            set_cfg(vec[v].bk, vec[v].e8, vec[v].pe, vec[v].od);
            repeat (4) @(negedge clk);
            exp_q.push_back({1'b1, 1'b0, vec[v].exp_ferr, vec[v].exp_perr, vec[v].exp_d});
            send_frame(vec[v].d, vec[v].e8, vec[v].pe, vec[v].pbit, vec[v].stopb, vec[v].bk, 1'b1);
            wait_done(4 * vec[v].bk + 20);
            check($sformatf("latency_%0d", v), rise_cyc - start_cyc, lat);
            pulse_read();
            check($sformatf("read_clear_%0d", v), {30'd0, rx_rdy, ovf}, 32'd0);
            check($sformatf("hold_%0d", v), {22'd0, ferr, perr, rx_data},
                  {22'd0, vec[v].exp_ferr, vec[v].exp_perr, vec[v].exp_d});
            repeat (3 * vec[v].bk) @(negedge clk);
        end

        // framing error with the line left low: IDLE immediately restarts
        set_cfg(16, 1'b1, 1'b0, 1'b0);
        exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 8'h3C});
        fork
            send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 16, 1'b0);
            begin
                for (int i = 0; i < 400 && state_dbg != S_DONE; i++) @(negedge clk);
                @(negedge clk);
                st_a = state_dbg;
                @(negedge clk);
                st_b = state_dbg;
            end
        join
        rx = 1'b1;
        check("ferr_then_idle", {29'd0, st_a}, {29'd0, S_IDLE});
        check("ferr_restart", {29'd0, st_b}, {29'd0, S_START});
        repeat (30) @(negedge clk);
        check("ferr_false_start_idle", {29'd0, state_dbg}, {29'd0, S_IDLE});
        check("ferr_flags", {20'd0, rx_rdy, ovf, ferr, perr, rx_data}, {20'd0, 4'b1010, 8'h3C});
        pulse_read();

        // short glitch is rejected as a false start
        repeat (5) @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
        check("glitch_flags", {20'd0, rx_rdy, ovf, ferr, perr, rx_data}, {20'd0, 4'b0010, 8'h3C});

        // overrun, read clear, then read colliding with DONE
        exp_q.push_back({4'b1000, 8'h11});
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 16, 1'b1);
        wait_done(100);
        repeat (4) @(negedge clk);
        exp_q.push_back({4'b1100, 8'h22});
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 16, 1'b1);
        wait_done(100);
        pulse_read();
        check("ovf_read_clear", {30'd0, rx_rdy, ovf}, 32'd0);
        check("ovf_data_hold", {24'd0, rx_data}, 32'h22);
        repeat (4) @(negedge clk);
        exp_q.push_back({4'b1000, 8'h33});
        send_frame(8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 16, 1'b1);
        wait_done(100);
        repeat (4) @(negedge clk);
        exp_q.push_back({4'b1000, 8'h44});
        fork
            send_frame(8'h44, 1'b1, 1'b0, 1'b0, 1'b1, 16, 1'b1);
            read_on_done();
        join
        wait_done(100);
        check("collide_rdy", {30'd0, rx_rdy, ovf}, 32'd2);

        // reset in the middle of the data bits of 0x5A
        repeat (4) @(negedge clk);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = (i == 1) ? 1'b1 : 1'b0;
            repeat (16) @(negedge clk);
        end
        rx = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midframe_reset_outputs", {20'd0, rx_rdy, ovf, ferr, perr, rx_data}, 32'd0);
        check("midframe_reset_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
        repeat (10) @(negedge clk);
        exp_q.push_back({4'b1000, 8'hC3});
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 16, 1'b1);
        wait_done(100);
        repeat (40) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
